tx_mix_ctrl: RTL and testbench

//  TX sequencer in front of the transmit mixer/NCO (mixtx1). Produces the 32-bit NCO phase word phi.

---
 rtl/tx_mix_ctrl.sv | 167 ++++++++++++++++
 tb/tb_tx_mix_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/tx_mix_ctrl.sv
// TX sequencer ahead of the transmit mixer: NCO phase accumulation, PTT-driven I/Q amplitude ramp,
// deferred retuning and mixer-valid tracking. Define TX_MIX_CTRL_PHASE_RESET_EN to zero phi at each key-up.
module tx_mix_ctrl #(
    parameter int RAMP_BITS   = 8,
    parameter int MIX_LAT     = 6,
    parameter int HANG_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ptt,
    input  logic [31:0]        freq_word,
    input  logic               freq_load,
    input  logic               in_valid,
    input  logic signed [17:0] i_in,
    input  logic signed [17:0] q_in,
    output logic [31:0]        phi,
    output logic signed [17:0] i_sig,
    output logic signed [17:0] q_sig,
    output logic               tx_active,
    output logic               ramp_done,
    output logic               mix_valid
);

    localparam int GW  = RAMP_BITS + 1;
    localparam int PW  = 20 + RAMP_BITS;
    localparam int MVD = MIX_LAT + 1;
    localparam int HW  = $clog2(HANG_CYCLES + 1);
    localparam logic [GW-1:0] GAIN_MAX = {1'b1, {RAMP_BITS{1'b0}}};
    localparam logic [HW-1:0] HANG_LAST = HW'(HANG_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RAMPUP,
        S_ON,
        S_RAMPDOWN,
        S_HANG
    } state_t;

    state_t          r_state, w_state_next;
    logic [GW-1:0]   r_gain, w_gain_next;
    logic [HW-1:0]   r_hang_cnt, w_hang_next;
    logic [31:0]     r_phi, r_freq_act, r_freq_pend;
    logic [MVD-1:0]  r_mv_pipe;
    logic signed [17:0] r_i_sig, r_q_sig;
    logic            w_tx_active;
    logic            w_phase_clr;
    logic            w_sig_zero;
    logic signed [PW-1:0] w_i_ext, w_q_ext, w_gain_ext, w_prod_i, w_prod_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_gain     <= '0;
            r_hang_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_gain     <= w_gain_next;
            r_hang_cnt <= w_hang_next;
        end
    end

    // A ptt reversal always wins over a gain step on the same clock, leaving the gain untouched.
    always_comb begin
        w_state_next = r_state;
        w_gain_next  = r_gain;
        w_hang_next  = r_hang_cnt;
        case (r_state)
            S_IDLE: begin
                w_gain_next = '0;
                w_hang_next = '0;
                if (ptt) w_state_next = S_RAMPUP;
            end
            S_RAMPUP: begin
                if (!ptt) begin
                    w_state_next = S_RAMPDOWN;
                end else if (r_gain == GAIN_MAX) begin
                    w_state_next = S_ON;
                end else if (in_valid) begin
                    w_gain_next = r_gain + 1'b1;
                    if (r_gain == GAIN_MAX - 1'b1) w_state_next = S_ON;
                end
            end
            S_ON: begin
                if (!ptt) w_state_next = S_RAMPDOWN;
            end
            S_RAMPDOWN: begin
                if (ptt) begin
                    w_state_next = S_RAMPUP;
                end else if (r_gain == '0) begin
                    w_state_next = S_HANG;
                    w_hang_next  = '0;
                end else if (in_valid) begin
                    w_gain_next = r_gain - 1'b1;
                    if (r_gain == GW'(1)) begin
                        w_state_next = S_HANG;
                        w_hang_next  = '0;
                    end
                end
            end
            S_HANG: begin
                w_gain_next = '0;
                if (ptt) begin
                    w_state_next = S_RAMPUP;
                    w_hang_next  = '0;
                end else if (r_hang_cnt == HANG_LAST) begin
                    w_state_next = S_IDLE;
                    w_hang_next  = '0;
                end else begin
                    w_hang_next = r_hang_cnt + 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign w_tx_active = (r_state != S_IDLE);
    assign w_sig_zero  = (r_state == S_IDLE) || (r_state == S_HANG);

`ifdef TX_MIX_CTRL_PHASE_RESET_EN
    assign w_phase_clr = (r_state == S_IDLE) && ptt;
`else
    assign w_phase_clr = 1'b0;
`endif

    // Retuning mid-transmission would glitch the carrier, so the active word only moves in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phi       <= '0;
            r_freq_act  <= '0;
            r_freq_pend <= '0;
        end else begin
            if (freq_load) r_freq_pend <= freq_word;
            if (r_state == S_IDLE) r_freq_act <= freq_load ? freq_word : r_freq_pend;
            r_phi <= w_phase_clr ? '0 : r_phi + r_freq_act;
        end
    end

    assign w_i_ext    = {{(PW-18){i_in[17]}}, i_in};
    assign w_q_ext    = {{(PW-18){q_in[17]}}, q_in};
    assign w_gain_ext = {{(PW-GW){1'b0}}, r_gain};
    assign w_prod_i   = w_i_ext * w_gain_ext;
    assign w_prod_q   = w_q_ext * w_gain_ext;

    // Taking bits above RAMP_BITS is an arithmetic shift, so rounding is toward -inf.
    always_ff @(posedge clk) begin
        if (rst || w_sig_zero) begin
            r_i_sig <= '0;
            r_q_sig <= '0;
        end else if (in_valid) begin
            r_i_sig <= w_prod_i[RAMP_BITS +: 18];
            r_q_sig <= w_prod_q[RAMP_BITS +: 18];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_mv_pipe <= '0;
        else     r_mv_pipe <= (r_mv_pipe << 1) | MVD'(in_valid & w_tx_active);
    end

    assign phi       = r_phi;
    assign i_sig     = r_i_sig;
    assign q_sig     = r_q_sig;
    assign tx_active = w_tx_active;
    assign ramp_done = (r_state == S_ON);
    assign mix_valid = r_mv_pipe[MVD-1];

endmodule

// File: tb/tb_tx_mix_ctrl.sv
// Directed bench for tx_mix_ctrl with RAMP_BITS=4: ramp table, ramp-down/hang, re-key, retune and wrap sequences.
module tb_tx_mix_ctrl;

    localparam int RB = 4;
    localparam int ML = 6;
    localparam int HC = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               ptt = 1'b0;
    logic [31:0]        freq_word = '0;
    logic               freq_load = 1'b0;
    logic               in_valid = 1'b0;
    logic signed [17:0] i_in = '0;
    logic signed [17:0] q_in = '0;
    logic [31:0]        phi;
    logic signed [17:0] i_sig;
    logic signed [17:0] q_sig;
    logic               tx_active;
    logic               ramp_done;
    logic               mix_valid;

    int checks = 0;
    int errors = 0;

    logic [31:0] mPhi  = '0;
    logic [31:0] mFreq = '0;
    logic        mClr  = 1'b0;

    typedef struct {
        int   iIn;
        int   qIn;
        int   expI;
        int   expQ;
        logic expRd;
        logic expMv;
    } rampVec_t;

    rampVec_t rampTab[17];
    int upI[17] = '{0, 62, 125, 187, 250, 312, 375, 437, 500, 562, 625, 687, 750, 812, 875, 937, 1000};
    int upQ[17] = '{0, -63, -125, -188, -250, -313, -375, -438, -500, -563, -625, -688, -750, -813, -875, -938, -1000};
    logic [31:0] wrapExp[4] = '{32'hC000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};

    tx_mix_ctrl #(.RAMP_BITS(RB), .MIX_LAT(ML), .HANG_CYCLES(HC)) dut (
        .clk       (clk),
        .rst       (rst),
        .ptt       (ptt),
        .freq_word (freq_word),
        .freq_load (freq_load),
        .in_valid  (in_valid),
        .i_in      (i_in),
        .q_in      (q_in),
        .phi       (phi),
        .i_sig     (i_sig),
        .q_sig     (q_sig),
        .tx_active (tx_active),
        .ramp_done (ramp_done),
        .mix_valid (mix_valid)
    );

    always #5 clk = ~clk;

    // Reference phase accumulator; the sequences below set mFreq at the clock the new word should apply.
    always @(posedge clk) begin
        if (rst) mPhi <= '0;
`ifdef TX_MIX_CTRL_PHASE_RESET_EN
        else if (mClr) mPhi <= '0;
`endif
        else mPhi <= mPhi + mFreq;
    end

    task automatic applyStimulus(input logic p, input logic v, input int iv, input int qv,
                                 input logic fl, input logic [31:0] fw);
        @(negedge clk);
        ptt       = p;
        in_valid  = v;
        i_in      = 18'(iv);
        q_in      = 18'(qv);
        freq_load = fl;
        freq_word = fw;
        @(posedge clk);
        #1;
    endtask

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input string name, input int expI, input int expQ,
                               input logic expTx, input logic expRd);
        checkVal({name, " i_sig"}, {{14{i_sig[17]}}, i_sig}, 32'(expI));
        checkVal({name, " q_sig"}, {{14{q_sig[17]}}, q_sig}, 32'(expQ));
        checkVal({name, " tx_active"}, {31'b0, tx_active}, {31'b0, expTx});
        checkVal({name, " ramp_done"}, {31'b0, ramp_done}, {31'b0, expRd});
        checkVal({name, " phi"}, phi, mPhi);
    endtask

    task automatic checkMv(input string name, input logic expMv);
        checkVal({name, " mix_valid"}, {31'b0, mix_valid}, {31'b0, expMv});
    endtask

    initial begin
        for (int n = 0; n < 17; n++) begin
            rampTab[n].iIn   = 1000;
            rampTab[n].qIn   = -1000;
            rampTab[n].expI  = upI[n];
            rampTab[n].expQ  = upQ[n];
            rampTab[n].expRd = (n >= 15);
            rampTab[n].expMv = (n >= 6);
        end

        // Reset held for two clocks
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", 0, 0, 1'b0, 1'b0);
        checkMv("reset", 1'b0);
        checkVal("reset phi", phi, 32'h0);

        // Tune in IDLE takes effect one clock after the load
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b1, 32'h0100_0000);
        checkVal("tune phi0", phi, 32'h0);
        mFreq = 32'h0100_0000;
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 32'h0);
        checkVal("tune phi1", phi, 32'h0100_0000);
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 32'h0);
        checkVal("tune phi2", phi, 32'h0200_0000);

        // Key up, then full ramp from the table
        mClr = 1'b1;
        applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 32'h0);
        mClr = 1'b0;
        checkOutput("keyup", 0, 0, 1'b1, 1'b0);
        for (int n = 0; n < 17; n++) begin
            applyStimulus(1'b1, 1'b1, rampTab[n].iIn, rampTab[n].qIn, 1'b0, 32'h0);
            checkOutput($sformatf("ramp%0d", n), rampTab[n].expI, rampTab[n].expQ, 1'b1, rampTab[n].expRd);
            checkMv($sformatf("ramp%0d", n), rampTab[n].expMv);
        end

        // Loads while ON are deferred; the last one should win
        applyStimulus(1'b1, 1'b0, 0, 0, 1'b1, 32'h2000_0000);
        checkOutput("on load1", 1000, -1000, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 0, 0, 1'b1, 32'h3000_0000);
        checkOutput("on load2", 1000, -1000, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 32'h0);
        checkOutput("on hold", 1000, -1000, 1'b1, 1'b1);

        // Unkey and ramp all the way down into HANG
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 32'h0);
        checkOutput("unkey", 1000, -1000, 1'b1, 1'b0);
        for (int k = 16; k >= 1; k--) begin
            applyStimulus(1'b0, 1'b1, 1000, -1000, 1'b0, 32'h0);
            checkOutput($sformatf("down%0d", k), upI[k], upQ[k], 1'b1, 1'b0);
        end
        for (int k = 1; k <= 16; k++) begin
            applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 32'h0);
            checkOutput($sformatf("hang%0d", k), 0, 0, (k < 16), 1'b0);
            checkMv($sformatf("hang%0d", k), (k <= 6));
        end

        // First IDLE clock copies the pending word; it shows in phi one clock later
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 32'h0);
        checkOutput("idle0", 0, 0, 1'b0, 1'b0);
        mFreq = 32'h3000_0000;
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 32'h0);
        checkOutput("idle1", 0, 0, 1'b0, 1'b0);

        // Partial ramp to gain 5, reverse, ramp down
        mClr = 1'b1;
        applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 32'h0);
        mClr = 1'b0;
        checkOutput("rekey", 0, 0, 1'b1, 1'b0);
        for (int n = 0; n < 5; n++) begin
            applyStimulus(1'b1, 1'b1, 1000, -1000, 1'b0, 32'h0);
            checkOutput($sformatf("pup%0d", n), upI[n], upQ[n], 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 32'h0);
        checkOutput("reverse", 250, -250, 1'b1, 1'b0);
        for (int k = 5; k >= 1; k--) begin
            applyStimulus(1'b0, 1'b1, 1000, -1000, 1'b0, 32'h0);
            checkOutput($sformatf("pdown%0d", k), upI[k], upQ[k], 1'b1, 1'b0);
        end

        // Re-key on the eighth HANG clock: tx_active must never drop
        for (int k = 1; k <= 7; k++) begin
            applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 32'h0);
            checkOutput($sformatf("phang%0d", k), 0, 0, 1'b1, 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 32'h0);
        checkOutput("hang rekey", 0, 0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1000, -1000, 1'b0, 32'h0);
        checkOutput("rekey strobe", 0, 0, 1'b1, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            applyStimulus(1'b1, 1'b0, 0, 0, 1'b0, 32'h0);
            checkMv($sformatf("mvdelay%0d", k), (k == 6));
        end

        // Negative sample at gain 1 rounds toward -inf
        applyStimulus(1'b1, 1'b1, -1, 1, 1'b0, 32'h0);
        checkOutput("neg gain1", -1, 0, 1'b1, 1'b0);

        // Reset mid-transmit
        mFreq = '0;
        @(negedge clk);
        rst      = 1'b1;
        ptt      = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midrst", 0, 0, 1'b0, 1'b0);
        checkMv("midrst", 1'b0);

        // Wrap test; an IDLE strobe must not raise mix_valid
        rst = 1'b0;
        applyStimulus(1'b0, 1'b1, 1000, -1000, 1'b1, 32'hC000_0000);
        checkOutput("wrap0", 0, 0, 1'b0, 1'b0);
        checkVal("wrap0 phi", phi, 32'h0);
        mFreq = 32'hC000_0000;
        for (int k = 1; k <= 7; k++) begin
            applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 32'h0);
            checkOutput($sformatf("wrap%0d", k), 0, 0, 1'b0, 1'b0);
            checkMv($sformatf("wrap%0d", k), 1'b0);
            if (k <= 4) checkVal($sformatf("wrap%0d const", k), phi, wrapExp[k-1]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
